// File: rtl/mcu_debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mcu_debug_pkg
//  Purpose  : Shared types and helpers for the MCU debug adapter: FSM states,
//             priority-encoded command, big-endian byte-lane helpers.
//  Revision : 1.0  initial release
// ============================================================================
package mcu_debug_pkg;

  localparam int RF_DEPTH = 32;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_REG      = 3'd2,
    S_MEM_REQ  = 3'd3,
    S_MEM_WAIT = 3'd4,
    S_RST_HOLD = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_PAUSE  = 3'd1,
    CMD_RESUME = 3'd2,
    CMD_RESET  = 3'd3,
    CMD_REG_RD = 3'd4,
    CMD_REG_WR = 3'd5,
    CMD_MEM_RD = 3'd6,
    CMD_MEM_WR = 3'd7
  } cmd_t;

  // Highest-priority strobe wins when the controller raises several at once.
  function automatic cmd_t decode_cmd(input logic p, input logic r, input logic rs,
                                      input logic rr, input logic rw,
                                      input logic mr, input logic mw);
    cmd_t c;
    if (p)       c = CMD_PAUSE;
    else if (r)  c = CMD_RESUME;
    else if (rs) c = CMD_RESET;
    else if (rr) c = CMD_REG_RD;
    else if (rw) c = CMD_REG_WR;
    else if (mr) c = CMD_MEM_RD;
    else if (mw) c = CMD_MEM_WR;
    else         c = CMD_NOP;
    return c;
  endfunction

  // State entered once the pipeline is known to be drained.
  function automatic state_t exec_state(input cmd_t c);
    state_t s;
    case (c)
      CMD_REG_RD, CMD_REG_WR: s = S_REG;
      CMD_MEM_RD, CMD_MEM_WR: s = S_MEM_REQ;
      default:                s = S_DONE;
    endcase
    return s;
  endfunction

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  function automatic logic [3:0] lane_be(input logic [1:0] off);
    return 4'b1000 >> off;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_debug_adapter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mcu_debug_adapter_if
//  Purpose  : Command/response link between mcu_controller (master) and the
//             debug adapter (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface mcu_debug_adapter_if;
  logic        valid;
  logic        pause;
  logic        resume;
  logic        reset;
  logic        reg_rd;
  logic        reg_wr;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_rw_byte;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic        mcu_busy;
  logic [31:0] d_rd;
  logic        error;

  modport master (
    output valid, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr,
           mem_rw_byte, addr, d_in,
    input  mcu_busy, d_rd, error
  );

  modport slave (
    input  valid, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr,
           mem_rw_byte, addr, d_in,
    output mcu_busy, d_rd, error
  );
endinterface
`default_nettype wire

// File: rtl/db_byte_lane.sv
`default_nettype none
// ============================================================================
//  Module   : db_byte_lane
//  Purpose  : Byte-lane steering for the memory port: byte enables, write-data
//             replication and zero-extended read-byte extraction.
//  Revision : 1.0  initial release
// ============================================================================
module db_byte_lane
  import mcu_debug_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic        is_byte,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  assign be = is_byte ? lane_be(offset) : 4'hF;

  // Byte writes put the low data byte on every lane; be picks the one that lands.
  generate
    for (genvar i = 0; i < 4; i++) begin : g_lane
      assign wdata_out[8*i +: 8] = is_byte ? wdata_in[7:0] : wdata_in[8*i +: 8];
    end
  endgenerate

  assign rdata_out = is_byte ? {24'h0, lane_byte(rdata_in, offset)} : rdata_in;

endmodule
`default_nettype wire

// File: rtl/mcu_debug_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : mcu_debug_adapter
//  Purpose  : Executes controller debug commands against the MCU: pipeline
//             stall/drain, reset pulse, register-file port, handshaked memory.
//  Revision : 1.0  initial release
// ============================================================================
module mcu_debug_adapter
  import mcu_debug_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int MEM_TIMEOUT   = 1024,
  parameter int DRAIN_TIMEOUT = 256
)(
  input  logic                 clk,
  input  logic                 rst_n,
  mcu_debug_adapter_if.slave   ctrl,
  output logic                 cpu_stall,
  output logic                 cpu_reset,
  input  logic                 cpu_idle,
  output logic [4:0]           rf_addr,
  output logic                 rf_we,
  output logic [31:0]          rf_wdata,
  input  logic [31:0]          rf_rdata,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_be,
  output logic                 mem_re,
  output logic                 mem_we,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata
);

  localparam int CNT_MAX_MD = (MEM_TIMEOUT > DRAIN_TIMEOUT) ? MEM_TIMEOUT : DRAIN_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_MD > RESET_CYCLES) ? CNT_MAX_MD : RESET_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  state_t             state;
  cmd_t               cmd_q;
  logic [31:0]        addr_q;
  logic [31:0]        d_in_q;
  logic               byte_q;
  logic               paused;
  logic               short_q;   // op reached DONE straight from IDLE: hold DONE one extra cycle
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        d_rd_q;
  logic               error_q;

  cmd_t               cmd_in;
  state_t             exec_in;
  logic               bad_in;
  logic               req_active;
  logic [3:0]         lane_be_w;
  logic [31:0]        lane_wdata;
  logic [31:0]        lane_rdata;

  assign cmd_in  = decode_cmd(ctrl.pause, ctrl.resume, ctrl.reset, ctrl.reg_rd,
                              ctrl.reg_wr, ctrl.mem_rd, ctrl.mem_wr);
  assign exec_in = exec_state(cmd_in);

  // Reject out-of-range register indices and misaligned word accesses up front.
  always_comb begin
    bad_in = 1'b0;
    case (cmd_in)
      CMD_REG_RD, CMD_REG_WR: bad_in = (ctrl.addr >= 32'(RF_DEPTH));
      CMD_MEM_RD, CMD_MEM_WR: bad_in = !ctrl.mem_rw_byte && (ctrl.addr[1:0] != 2'b00);
      default:                bad_in = 1'b0;
    endcase
  end

  db_byte_lane u_lane (
    .offset    (addr_q[1:0]),
    .is_byte   (byte_q),
    .wdata_in  (d_in_q),
    .rdata_in  (mem_rdata),
    .be        (lane_be_w),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

  assign req_active = (state == S_MEM_REQ) || (state == S_MEM_WAIT);

  assign ctrl.mcu_busy = (state != S_IDLE);
  assign ctrl.d_rd     = d_rd_q;
  assign ctrl.error    = error_q;

  assign cpu_stall = paused || (state == S_DRAIN) || (state == S_REG) || req_active;
  assign cpu_reset = (state == S_RST_HOLD);

  assign rf_addr   = addr_q[4:0];
  assign rf_wdata  = d_in_q;
  assign rf_we     = (state == S_REG) && (cmd_q == CMD_REG_WR) && (addr_q[4:0] != 5'd0);

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = lane_wdata;
  assign mem_be    = req_active ? lane_be_w : 4'h0;
  assign mem_re    = req_active && (cmd_q == CMD_MEM_RD);
  assign mem_we    = req_active && (cmd_q == CMD_MEM_WR);

  // Command FSM with its counters and the d_rd/error result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      d_in_q  <= '0;
      byte_q  <= 1'b0;
      paused  <= 1'b0;
      short_q <= 1'b0;
      cnt     <= '0;
      d_rd_q  <= '0;
      error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctrl.valid) begin
            cmd_q   <= cmd_in;
            addr_q  <= ctrl.addr;
            d_in_q  <= ctrl.d_in;
            byte_q  <= ctrl.mem_rw_byte;
            error_q <= 1'b0;
            cnt     <= '0;
            short_q <= 1'b0;
            if (bad_in) begin
              error_q <= 1'b1;
              short_q <= 1'b1;
              state   <= S_DONE;
            end else begin
              case (cmd_in)
                CMD_NOP: begin
                  short_q <= 1'b1;
                  state   <= S_DONE;
                end
                CMD_RESUME: begin
                  paused  <= 1'b0;
                  short_q <= 1'b1;
                  state   <= S_DONE;
                end
                CMD_RESET: state <= S_RST_HOLD;
                default: begin
                  if (cmd_in == CMD_PAUSE) paused <= 1'b1;
                  if (!cpu_idle) begin
                    state <= S_DRAIN;
                  end else begin
                    state   <= exec_in;
                    short_q <= (exec_in == S_DONE);
                  end
                end
              endcase
            end
          end
        end

        S_DRAIN: begin
          if (cpu_idle) begin
            cnt   <= '0;
            state <= exec_state(cmd_q);
          end else if (cnt == CNT_W'(DRAIN_TIMEOUT - 1)) begin
            error_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_REG: begin
          if (cmd_q == CMD_REG_RD)
            d_rd_q <= (addr_q[4:0] == 5'd0) ? 32'h0 : rf_rdata;
          state <= S_DONE;
        end

        S_MEM_REQ, S_MEM_WAIT: begin
          if (mem_ack) begin
            if (cmd_q == CMD_MEM_RD) d_rd_q <= lane_rdata;
            state <= S_DONE;
          end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            error_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= S_MEM_WAIT;
          end
        end

        S_RST_HOLD: begin
          if (cnt == CNT_W'(RESET_CYCLES - 1)) state <= S_DONE;
          else                                 cnt   <= cnt + 1'b1;
        end

        S_DONE: begin
          if (short_q) short_q <= 1'b0;
          else         state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcu_debug_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcu_debug_adapter
//  Purpose  : Directed self-checking bench for mcu_debug_adapter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mcu_debug_adapter;

  localparam logic [6:0] P  = 7'b1000000;
  localparam logic [6:0] R  = 7'b0100000;
  localparam logic [6:0] RS = 7'b0010000;
  localparam logic [6:0] RR = 7'b0001000;
  localparam logic [6:0] RW = 7'b0000100;
  localparam logic [6:0] MR = 7'b0000010;
  localparam logic [6:0] MW = 7'b0000001;
  localparam int WAIT_MAX = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_stall, cpu_reset, cpu_idle;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_wdata, rf_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_re, mem_we, mem_ack;

  logic [31:0] rf_mem [32];
  int          ack_delay;
  int          req_cnt = 0;
  int          rf_we_cnt = 0, we_cycles = 0, re_cycles = 0, rst_cycles = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_be = '0;

  int checks = 0;
  int errors = 0;

  mcu_debug_adapter_if ctrl ();

  mcu_debug_adapter dut (
    .clk (clk), .rst_n (rst_n), .ctrl (ctrl.slave),
    .cpu_stall (cpu_stall), .cpu_reset (cpu_reset), .cpu_idle (cpu_idle),
    .rf_addr (rf_addr), .rf_we (rf_we), .rf_wdata (rf_wdata), .rf_rdata (rf_rdata),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_be (mem_be),
    .mem_re (mem_re), .mem_we (mem_we), .mem_ack (mem_ack), .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // CPU model: pipeline reports drained one cycle after it is stalled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_idle <= 1'b0;
    else        cpu_idle <= cpu_stall;
  end

  // Register file model; index 0 returns junk so a forced zero is visible.
  assign rf_rdata = (rf_addr == 5'd0) ? 32'h0BAD0BAD : rf_mem[rf_addr];

  // Memory responder: ack on the request cycle numbered ack_delay (0 = same cycle).
  assign mem_ack = (mem_re || mem_we) && (ack_delay >= 0) && (req_cnt == ack_delay);

  always @(posedge clk) begin
    req_cnt <= (mem_re || mem_we) ? req_cnt + 1 : 0;
    if (rf_we) begin
      rf_mem[rf_addr] <= rf_wdata;
      rf_we_cnt       <= rf_we_cnt + 1;
    end
    if (mem_we) begin
      we_cycles <= we_cycles + 1;
      cap_be    <= mem_be;
      cap_wdata <= mem_wdata;
      cap_addr  <= mem_addr;
    end
    if (mem_re) begin
      re_cycles <= re_cycles + 1;
      cap_be    <= mem_be;
      cap_addr  <= mem_addr;
    end
    if (cpu_reset) rst_cycles <= rst_cycles + 1;
  end

  task automatic send(input logic [6:0] s, input logic b, input logic [31:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    {ctrl.pause, ctrl.resume, ctrl.reset, ctrl.reg_rd, ctrl.reg_wr, ctrl.mem_rd, ctrl.mem_wr} = s;
    ctrl.valid = 1'b1; ctrl.mem_rw_byte = b; ctrl.addr = a; ctrl.d_in = d;
    @(negedge clk);
    {ctrl.pause, ctrl.resume, ctrl.reset, ctrl.reg_rd, ctrl.reg_wr, ctrl.mem_rd, ctrl.mem_wr} = '0;
    ctrl.valid = 1'b0;
  endtask

  // Counts busy cycles starting with the current one; returns at the first idle negedge.
  task automatic wait_idle(output int n);
    n = 0;
    while (ctrl.mcu_busy && n < WAIT_MAX) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({ctrl.mcu_busy, ctrl.error, cpu_stall, cpu_reset, rf_we, mem_re, mem_we, mem_be} !== 11'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0",
               {ctrl.mcu_busy, ctrl.error, cpu_stall, cpu_reset, rf_we, mem_re, mem_we, mem_be});
    end
    checks++;
    if (ctrl.d_rd !== 32'h0) begin errors++; $display("FAIL reset_d_rd: got %h required 0", ctrl.d_rd); end
  endtask

  task automatic test_pause();
    int n;
    send(P, 1'b0, 32'h0, 32'h0);
    wait_idle(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL pause_busy_len: got %0d required 3", n); end
    checks++;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL pause_stall: got %b required 1", cpu_stall); end
  endtask

  task automatic test_reg();
    int n, base;
    base = rf_we_cnt;
    send(RW, 1'b0, 32'd5, 32'hDEADBEEF);
    wait_idle(n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL reg_wr_busy_len: got %0d required 2", n); end
    checks++;
    if (rf_we_cnt - base !== 1) begin errors++; $display("FAIL reg_wr_pulses: got %0d required 1", rf_we_cnt - base); end
    send(RR, 1'b0, 32'd5, 32'h0);
    wait_idle(n);
    checks++;
    if (ctrl.d_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL reg_rd5: got %h required deadbeef", ctrl.d_rd); end
    base = rf_we_cnt;
    send(RW, 1'b0, 32'd0, 32'h12345678);
    wait_idle(n);
    checks++;
    if (rf_we_cnt - base !== 0) begin errors++; $display("FAIL reg_wr0_dropped: got %0d required 0", rf_we_cnt - base); end
    send(RR, 1'b0, 32'd0, 32'h0);
    wait_idle(n);
    checks++;
    if (ctrl.d_rd !== 32'h0) begin errors++; $display("FAIL reg_rd0: got %h required 0", ctrl.d_rd); end
    send(RR, 1'b0, 32'd40, 32'h0);
    wait_idle(n);
    checks++;
    if ({ctrl.error, n[3:0]} !== {1'b1, 4'd2}) begin
      errors++; $display("FAIL reg_range_err: got err=%b len=%0d required err=1 len=2", ctrl.error, n);
    end
  endtask

  task automatic test_resume();
    int n;
    send(R, 1'b0, 32'h0, 32'h0);
    wait_idle(n);
    checks++;
    if ({n[3:0], cpu_stall, ctrl.error} !== {4'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL resume: got len=%0d stall=%b err=%b required 2 0 0", n, cpu_stall, ctrl.error);
    end
  endtask

  task automatic test_mem_word_wr();
    int n, base;
    base = we_cycles;
    ack_delay = 3;
    send(MW, 1'b0, 32'h100, 32'h11223344);
    checks++;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL memwr_autostall: got %b required 1", cpu_stall); end
    wait_idle(n);
    checks++;
    if (n !== 7) begin errors++; $display("FAIL memwr_busy_len: got %0d required 7", n); end
    checks++;
    if ({cap_be, cap_wdata, cap_addr} !== {4'hF, 32'h11223344, 32'h100}) begin
      errors++; $display("FAIL memwr_bus: got be=%h wd=%h a=%h required f 11223344 100", cap_be, cap_wdata, cap_addr);
    end
    checks++;
    if (we_cycles - base !== 4) begin errors++; $display("FAIL memwr_req_len: got %0d required 4", we_cycles - base); end
    checks++;
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL memwr_release: got %b required 0", cpu_stall); end
  endtask

  task automatic test_mem_byte();
    int n;
    ack_delay = 0;
    mem_rdata = 32'hAABBCCDD;
    send(MR, 1'b1, 32'h102, 32'h0);
    wait_idle(n);
    checks++;
    if ({ctrl.d_rd, cap_addr, cap_be} !== {32'h000000CC, 32'h100, 4'b0010}) begin
      errors++; $display("FAIL byte_rd: got d=%h a=%h be=%b required cc 100 0010", ctrl.d_rd, cap_addr, cap_be);
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL byte_rd_len: got %0d required 4", n); end
    send(MW, 1'b1, 32'h103, 32'h1234565A);
    wait_idle(n);
    checks++;
    if ({cap_be, cap_wdata, cap_addr} !== {4'b0001, 32'h5A5A5A5A, 32'h100}) begin
      errors++; $display("FAIL byte_wr: got be=%b wd=%h a=%h required 0001 5a5a5a5a 100", cap_be, cap_wdata, cap_addr);
    end
  endtask

  task automatic test_mem_errors();
    int n, base;
    base = re_cycles;
    send(MR, 1'b0, 32'h101, 32'h0);
    wait_idle(n);
    checks++;
    if ({ctrl.error, n[3:0], cpu_stall} !== {1'b1, 4'd2, 1'b0}) begin
      errors++; $display("FAIL misalign: got err=%b len=%0d stall=%b required 1 2 0", ctrl.error, n, cpu_stall);
    end
    checks++;
    if (re_cycles - base !== 0) begin errors++; $display("FAIL misalign_no_req: got %0d required 0", re_cycles - base); end
    ack_delay = -1;
    base = re_cycles;
    send(MR, 1'b0, 32'h200, 32'h0);
    checks++;
    if (ctrl.error !== 1'b0) begin errors++; $display("FAIL err_clear_on_accept: got %b required 0", ctrl.error); end
    wait_idle(n);
    checks++;
    if (n !== 1027) begin errors++; $display("FAIL timeout_len: got %0d required 1027", n); end
    checks++;
    if ({ctrl.error, mem_re} !== 2'b10) begin
      errors++; $display("FAIL timeout_err: got err=%b re=%b required 1 0", ctrl.error, mem_re);
    end
    checks++;
    if (re_cycles - base !== 1024) begin errors++; $display("FAIL timeout_req_len: got %0d required 1024", re_cycles - base); end
    checks++;
    if (ctrl.d_rd !== 32'h000000CC) begin errors++; $display("FAIL timeout_d_rd: got %h required cc", ctrl.d_rd); end
  endtask

  task automatic test_reset_cmd();
    int n, base_rst, base_we;
    send(P, 1'b0, 32'h0, 32'h0);
    wait_idle(n);
    base_rst = rst_cycles;
    base_we  = rf_we_cnt;
    send(RS, 1'b0, 32'h0, 32'h0);
    send(RW, 1'b0, 32'd7, 32'h77);
    wait_idle(n);
    checks++;
    if (rst_cycles - base_rst !== 16) begin errors++; $display("FAIL rst_len: got %0d required 16", rst_cycles - base_rst); end
    checks++;
    if (rf_we_cnt - base_we !== 0) begin errors++; $display("FAIL busy_valid_ignored: got %0d required 0", rf_we_cnt - base_we); end
    checks++;
    if ({cpu_stall, cpu_reset} !== 2'b10) begin
      errors++; $display("FAIL rst_paused_kept: got stall=%b rst=%b required 1 0", cpu_stall, cpu_reset);
    end
    send(R, 1'b0, 32'h0, 32'h0);
    wait_idle(n);
    checks++;
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_resume: got %b required 0", cpu_stall); end
  endtask

  task automatic test_async_reset();
    int n, base;
    ack_delay = -1;
    send(MW, 1'b0, 32'h300, 32'h55);
    repeat (4) @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL pre_rst_req: got %b required 1", mem_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ctrl.mcu_busy, ctrl.error, cpu_stall, cpu_reset, mem_we, mem_re, mem_be, ctrl.d_rd} !== 41'h0) begin
      errors++; $display("FAIL async_rst: got busy=%b stall=%b we=%b be=%h d=%h required all 0",
                         ctrl.mcu_busy, cpu_stall, mem_we, mem_be, ctrl.d_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 1;
    mem_rdata = 32'hCAFEF00D;
    send(MR, 1'b0, 32'h400, 32'h0);
    wait_idle(n);
    checks++;
    if ({ctrl.d_rd, ctrl.error, n[3:0]} !== {32'hCAFEF00D, 1'b0, 4'd5}) begin
      errors++; $display("FAIL post_rst_rd: got d=%h err=%b len=%0d required cafef00d 0 5", ctrl.d_rd, ctrl.error, n);
    end
  endtask

  task automatic test_priority();
    int n, base;
    base = we_cycles;
    ack_delay = 0;
    send(P | MW, 1'b0, 32'h500, 32'h99);
    wait_idle(n);
    checks++;
    if ({we_cycles - base, cpu_stall} !== {32'd0, 1'b1}) begin
      errors++; $display("FAIL prio_pause: got writes=%0d stall=%b required 0 1", we_cycles - base, cpu_stall);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ack_delay = -1;
    mem_rdata = 32'h0;
    ctrl.valid = 1'b0; ctrl.mem_rw_byte = 1'b0; ctrl.addr = '0; ctrl.d_in = '0;
    {ctrl.pause, ctrl.resume, ctrl.reset, ctrl.reg_rd, ctrl.reg_wr, ctrl.mem_rd, ctrl.mem_wr} = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_pause();
    test_reg();
    test_resume();
    test_mem_word_wr();
    test_mem_byte();
    test_mem_errors();
    test_reset_cmd();
    test_async_reset();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
